// File: rtl/zxnet_pkg.sv
// Shared constants for the ZX network card interrupt path: FSM encoding and pulse timing defaults.
package zxnet_pkg;

  localparam logic [1:0] ST_IDLE   = 2'b00;
  localparam logic [1:0] ST_ASSERT = 2'b01;
  localparam logic [1:0] ST_HOLD   = 2'b10;

  localparam int unsigned INT_WIDTH_DEFAULT = 32;
  localparam int unsigned HOLDOFF_DEFAULT   = 16;

  typedef enum logic [1:0] {
    StIdle   = ST_IDLE,
    StAssert = ST_ASSERT,
    StHold   = ST_HOLD
  } zx_int_state_e;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/sync_bit.sv
// Multi-stage single-bit synchroniser with asynchronous active-low reset to a chosen level.
module sync_bit #(
  parameter int unsigned STAGES    = 2,
  parameter logic        RESET_VAL = 1'b0
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] sync_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= {STAGES{RESET_VAL}};
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d_i};
    end
  end

  assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/zx_int_ctrl.sv
// Interrupt controller: synchronises and masks card interrupt sources and sequences a
// fixed-width, re-armable /INT pulse onto the ZX bus with a hold-off gap between pulses.
module zx_int_ctrl
  import zxnet_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned INT_WIDTH   = INT_WIDTH_DEFAULT,
  parameter int unsigned HOLDOFF     = HOLDOFF_DEFAULT
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       w5300_int_n,
  input  logic       sl811_intrq,
  input  logic       ena_w5300_int,
  input  logic       ena_sl811_int,
  input  logic       ena_zxbus_int,
  input  logic       int_ack,
  output logic       internal_int,
  output logic       src_w5300,
  output logic       src_sl811,
  output logic       zx_int_n,
  output logic [1:0] int_state
);

  localparam int unsigned CntW = $clog2(max_u(INT_WIDTH, HOLDOFF)) + 1;
  localparam logic [CntW-1:0] IntLoad  = CntW'(INT_WIDTH - 1);
  localparam logic [CntW-1:0] HoldLoad = CntW'(HOLDOFF - 1);

  zx_int_state_e   state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            internal_int_q;
  logic            zx_int_n_q;
  logic            pending;

  sync_bit #(
    .STAGES    (SYNC_STAGES),
    .RESET_VAL (1'b0)
  ) u_sync_w5300 (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .d_i    (~w5300_int_n),
    .q_o    (src_w5300)
  );

  sync_bit #(
    .STAGES    (SYNC_STAGES),
    .RESET_VAL (1'b0)
  ) u_sync_sl811 (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .d_i    (sl811_intrq),
    .q_o    (src_sl811)
  );

  assign pending = (src_w5300 & ena_w5300_int) | (src_sl811 & ena_sl811_int);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (internal_int_q && ena_zxbus_int) begin
          state_d = StAssert;
          cnt_d   = IntLoad;
        end
      end
      StAssert: begin
        // Ack and disable share the normal expiry path so the hold-off gap always follows.
        if ((cnt_q == '0) || int_ack || !ena_zxbus_int) begin
          state_d = StHold;
          cnt_d   = HoldLoad;
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      StHold: begin
        if (cnt_q == '0) begin
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      default: begin
        state_d = StIdle;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= StIdle;
      cnt_q          <= '0;
      internal_int_q <= 1'b0;
      zx_int_n_q     <= 1'b1;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      internal_int_q <= pending;
      zx_int_n_q     <= (state_d != StAssert);
    end
  end

  assign internal_int = internal_int_q;
  assign zx_int_n     = zx_int_n_q;
  assign int_state    = state_q;

endmodule
